sad_search_engine: RTL and testbench

Row-streaming, parametrised SAD engine for block-matching motion search. It accepts one row of current and reference pixels per handshake beat and supports 4x4, 8x8 and 16x16 block modes selected per candidate. It emits a backpressurable per-candidate SAD and tracks the minimum SAD and its candidate index across a search window. It sits between the reference-fetch row buffer and the mode-decision logic, and supersedes the single-shot combinational 16x16 SAD model.

---
 rtl/sad_search_engine_pkg.sv | 26 ++
 rtl/sad_search_engine_if.sv | 35 +++
 rtl/sad_search_engine_row_absdiff.sv | 45 ++++
 rtl/sad_search_engine.sv | 165 ++++++++++++++++
 tb/tb_sad_search_engine.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sad_search_engine_pkg.sv
// Shared types and elaboration helpers for the row-streaming SAD search engine.
// Block-mode decoding lives here so the datapath and controller agree on N.
package sad_pkg;

    typedef enum logic [1:0] {
        SAD_4X4   = 2'd0,
        SAD_8X8   = 2'd1,
        SAD_16X16 = 2'd2
    } blk_mode_e;

    function automatic int sad_width(input int dwidth, input int blk);
        return dwidth + 2 * $clog2(blk);
    endfunction

    // Mode 3 is reserved and behaves as 16x16; N never exceeds the lane count.
    function automatic int mode_dim(input logic [1:0] mode, input int blk);
        int n;
        case (blk_mode_e'(mode))
            SAD_4X4: n = 4;
            SAD_8X8: n = 8;
            default: n = 16;
        endcase
        return (n > blk) ? blk : n;
    endfunction

endpackage

// File: rtl/sad_search_engine_if.sv
// Row-beat input, per-candidate result output and search-best output of the engine.
// master = upstream row buffer plus downstream consumer; slave = the engine.
interface sad_search_engine_if #(
    parameter int DWIDTH = 8,
    parameter int BLK    = 16,
    parameter int IDXW   = 8
);
    localparam int SW = sad_pkg::sad_width(DWIDTH, BLK);

    logic [BLK*DWIDTH-1:0] din_row;
    logic [BLK*DWIDTH-1:0] ref_row;
    logic [1:0]            blk_mode;
    logic [IDXW-1:0]       cand_idx;
    logic                  cand_last;
    logic                  row_vld;
    logic                  row_rdy;
    logic [SW-1:0]         sad;
    logic [IDXW-1:0]       sad_idx;
    logic                  sad_vld;
    logic                  sad_rdy;
    logic [SW-1:0]         best_sad;
    logic [IDXW-1:0]       best_idx;
    logic                  best_vld;

    modport master (
        output din_row, ref_row, blk_mode, cand_idx, cand_last, row_vld, sad_rdy,
        input  row_rdy, sad, sad_idx, sad_vld, best_sad, best_idx, best_vld
    );

    modport slave (
        input  din_row, ref_row, blk_mode, cand_idx, cand_last, row_vld, sad_rdy,
        output row_rdy, sad, sad_idx, sad_vld, best_sad, best_idx, best_vld
    );

endinterface

// File: rtl/sad_search_engine_row_absdiff.sv
// Stage 1 of the SAD pipeline: per-lane |din-ref| with lanes >= dim masked off,
// summed into one registered row sum that freezes while en is low.
module sad_row_absdiff #(
    parameter  int DWIDTH = 8,
    parameter  int BLK    = 16,
    localparam int DIMW   = $clog2(BLK) + 1,
    localparam int RSW    = DWIDTH + $clog2(BLK)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [DIMW-1:0]       dim,
    input  logic [BLK*DWIDTH-1:0] din_row,
    input  logic [BLK*DWIDTH-1:0] ref_row,
    output logic [RSW-1:0]        row_sum
);

    logic [DWIDTH:0]   diff;
    logic [DWIDTH-1:0] mag;
    logic [RSW-1:0]    sum;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        diff = '0;
        mag  = '0;
        sum  = '0;
        for (int k = 0; k < BLK; k++) begin
            diff = {1'b0, din_row[k*DWIDTH +: DWIDTH]} - {1'b0, ref_row[k*DWIDTH +: DWIDTH]};
            mag  = diff[DWIDTH] ? DWIDTH'(~diff + 1'b1) : diff[DWIDTH-1:0];
            if (k < int'(dim)) begin
                sum = sum + RSW'(mag);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_sum <= '0;
        end else if (en) begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            row_sum <= sum;
        end
    end

endmodule

// File: rtl/sad_search_engine.sv
// Row-streaming SAD engine: row counter/FSM, stage-2 accumulator, held result
// register and running-minimum tracker across a search window.
module sad_search_engine
    import sad_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int BLK    = 16,
    parameter int IDXW   = 8
) (
    input logic              clk,
    input logic              rstn,
    sad_search_engine_if.slave bus
);

    localparam int SW   = sad_width(DWIDTH, BLK);
    localparam int CW   = $clog2(BLK);
    localparam int DIMW = CW + 1;
    localparam int RSW  = DWIDTH + CW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic            rdy_q, en, accept, row_first, row_last;
    logic [CW-1:0]   row_cnt;
    logic [1:0]      row_state, out_state;
    logic [DIMW-1:0] n_lat, eff_n;
    logic [IDXW-1:0] idx_lat;

    logic            s1_vld, s1_first, s1_last, s1_cand_last;
    logic [IDXW-1:0] s1_idx;
    logic [RSW-1:0]  row_sum;

    logic [SW-1:0]   acc, acc_next, sad_q;
    logic [IDXW-1:0] sad_idx_q;
    logic            out_last;

    logic            first, hs, take, best_vld_q;
    logic [SW-1:0]   run_min, min_next, best_sad_q;
    logic [IDXW-1:0] run_idx, idx_next, best_idx_q;

    // Only a held, unaccepted result stalls the pipe; row_rdy stays low until reset has released.
    assign en          = !(bus.sad_vld && !bus.sad_rdy);
    assign bus.row_rdy = rdy_q && en;
    assign accept      = bus.row_vld && bus.row_rdy;
    assign row_first   = (row_state == ST_IDLE);
    assign eff_n       = row_first ? DIMW'(mode_dim(bus.blk_mode, BLK)) : n_lat;
    assign row_last    = ({1'b0, row_cnt} == (eff_n - DIMW'(1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_q     <= 1'b0;
            row_cnt   <= '0;
            row_state <= ST_IDLE;
            n_lat     <= '0;
            idx_lat   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                if (row_first) begin
                    n_lat   <= eff_n;
                    idx_lat <= bus.cand_idx;
                end
                if (row_last) begin
                    row_cnt   <= '0;
                    row_state <= ST_IDLE;
                end else begin
                    row_cnt   <= row_cnt + CW'(1);
                    row_state <= ST_ACC;
                end
            end
        end
    end

    sad_row_absdiff #(.DWIDTH(DWIDTH), .BLK(BLK)) u_absdiff (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .dim     (eff_n),
        .din_row (bus.din_row),
        .ref_row (bus.ref_row),
        .row_sum (row_sum)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld       <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            s1_cand_last <= 1'b0;
            s1_idx       <= '0;
        end else if (en) begin
            s1_vld       <= accept;
            s1_first     <= row_first;
            s1_last      <= row_last;
            s1_cand_last <= bus.cand_last;
            s1_idx       <= row_first ? bus.cand_idx : idx_lat;
        end
    end

    assign acc_next = (s1_first ? SW'(0) : acc) + SW'(row_sum);

    // A new result may load in the same cycle the previous one is handed off.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc       <= '0;
            sad_q     <= '0;
            sad_idx_q <= '0;
            out_last  <= 1'b0;
            out_state <= ST_IDLE;
        end else if (en) begin
            if (s1_vld) begin
                acc <= acc_next;
            end
            if (s1_vld && s1_last) begin
                sad_q     <= acc_next;
                sad_idx_q <= s1_idx;
                out_last  <= s1_cand_last;
                out_state <= ST_OUT;
            end else begin
                out_state <= ST_IDLE;
            end
        end
    end

    assign bus.sad     = sad_q;
    assign bus.sad_idx = sad_idx_q;
    assign bus.sad_vld = (out_state == ST_OUT);

    // Strict less-than keeps the earlier candidate on ties.
    assign hs       = bus.sad_vld && bus.sad_rdy;
    assign take     = first || (sad_q < run_min);
    assign min_next = take ? sad_q : run_min;
    assign idx_next = take ? sad_idx_q : run_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first      <= 1'b1;
            run_min    <= '0;
            run_idx    <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
            best_vld_q <= 1'b0;
        end else begin
            best_vld_q <= 1'b0;
            if (hs) begin
                run_min <= min_next;
                run_idx <= idx_next;
                if (out_last) begin
                    best_sad_q <= min_next;
                    best_idx_q <= idx_next;
                    best_vld_q <= 1'b1;
                    first      <= 1'b1;
                end else begin
                    first <= 1'b0;
                end
            end
        end
    end

    assign bus.best_sad = best_sad_q;
    assign bus.best_idx = best_idx_q;
    assign bus.best_vld = best_vld_q;

endmodule

// File: tb/tb_sad_search_engine.sv
// Directed bench for sad_search_engine: hand-computed SADs, latency, stall,
// ignored-field, search-best and mid-block reset scenarios.
module tb_sad_search_engine;

    localparam int DWIDTH = 8;
    localparam int BLK    = 16;
    localparam int IDXW   = 8;
    localparam int W      = DWIDTH * BLK;

    logic clk = 1'b0;
    logic rstn;

    sad_search_engine_if #(.DWIDTH(DWIDTH), .BLK(BLK), .IDXW(IDXW)) bus ();

    sad_search_engine #(.DWIDTH(DWIDTH), .BLK(BLK), .IDXW(IDXW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks    = 0;
    int n_pass      = 0;
    int best_pulses = 0;
    int q_sad[$];
    int q_idx[$];

    always @(negedge clk) begin
        if (rstn && bus.sad_vld && bus.sad_rdy) begin
            q_sad.push_back(int'(bus.sad));
            q_idx.push_back(int'(bus.sad_idx));
        end
        if (bus.best_vld) best_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // All lanes = base except lane k = v.
    function automatic logic [W-1:0] one(input int base, input int k, input int v);
        logic [W-1:0] r;
        for (int i = 0; i < BLK; i++) r[i*DWIDTH +: DWIDTH] = DWIDTH'((i == k) ? v : base);
        return r;
    endfunction

    // Lanes below n = lo, the rest = hi.
    function automatic logic [W-1:0] split(input int lo, input int hi, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < BLK; i++) r[i*DWIDTH +: DWIDTH] = DWIDTH'((i < n) ? lo : hi);
        return r;
    endfunction

    task automatic send_row(input logic [W-1:0] d, input logic [W-1:0] r,
                            input int mode, input int idx, input bit cl);
        int waited;
        waited        = 0;
        bus.din_row   = d;
        bus.ref_row   = r;
        bus.blk_mode  = 2'(mode);
        bus.cand_idx  = IDXW'(idx);
        bus.cand_last = cl;
        bus.row_vld   = 1'b1;
        @(negedge clk);
        while (!bus.row_rdy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.row_rdy) check("row_accept", int'(bus.row_rdy), 1);
        @(posedge clk);
        #1;
        bus.row_vld = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int s, input int i);
        if (q_sad.size() > 0) begin
            check({tag, "_sad"}, q_sad.pop_front(), s);
            check({tag, "_idx"}, q_idx.pop_front(), i);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rstn          = 1'b0;
        bus.row_vld   = 1'b0;
        bus.sad_rdy   = 1'b1;
        bus.din_row   = '0;
        bus.ref_row   = '0;
        bus.blk_mode  = 2'd0;
        bus.cand_idx  = '0;
        bus.cand_last = 1'b0;
        #1;
        check("rst_row_rdy",  int'(bus.row_rdy),  0);
        check("rst_sad",      int'(bus.sad),      0);
        check("rst_sad_idx",  int'(bus.sad_idx),  0);
        check("rst_sad_vld",  int'(bus.sad_vld),  0);
        check("rst_best_sad", int'(bus.best_sad), 0);
        check("rst_best_idx", int'(bus.best_idx), 0);
        check("rst_best_vld", int'(bus.best_vld), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check("rel_row_rdy_before_edge", int'(bus.row_rdy), 0);
        wait_cycles(1);
        check("rel_row_rdy_after_edge", int'(bus.row_rdy), 1);

        // 16x16 saturated block: 255*256, result two cycles after the last row.
        q_sad.delete(); q_idx.delete();
        for (int r = 0; r < 16; r++) send_row(one(255, 0, 255), '0, 2, 1, 1'b0);
        @(negedge clk);
        check("t1_vld_T1", int'(bus.sad_vld), 0);
        @(negedge clk);
        check("t1_vld_T2", int'(bus.sad_vld), 1);
        check("t1_sad_T2", int'(bus.sad), 65280);
        wait_cycles(3);
        check("t1_count", q_sad.size(), 1);
        pop_check("t1", 65280, 1);

        // 4x4 with large differences parked on masked lanes: 4 rows * 4 lanes * 7.
        q_sad.delete(); q_idx.delete();
        p0 = best_pulses;
        for (int r = 0; r < 4; r++) send_row(split(10, 255, 4), split(3, 0, 4), 0, 2, r == 3);
        wait_cycles(5);
        check("t2_count", q_sad.size(), 1);
        pop_check("t2", 112, 2);
        check("t2_best_sad", int'(bus.best_sad), 112);
        check("t2_best_idx", int'(bus.best_idx), 2);
        check("t2_best_pulses", best_pulses - p0, 1);

        // Three 8x8 candidates 100/50/50: tie keeps idx 6; lane 12 garbage is masked.
        q_sad.delete(); q_idx.delete();
        p0 = best_pulses;
        send_row(one(0, 0, 100), '0, 1, 5, 1'b0);
        for (int r = 1; r < 8; r++) send_row(one(9, 12, 200), one(9, 12, 0), 1, 5, 1'b0);
        send_row(one(0, 7, 50), '0, 1, 6, 1'b0);
        for (int r = 1; r < 8; r++) send_row(one(9, 12, 200), one(9, 12, 0), 1, 6, 1'b0);
        send_row('0, one(0, 2, 50), 1, 7, 1'b0);
        for (int r = 1; r < 8; r++) send_row(one(9, 12, 200), one(9, 12, 0), 1, 7, r == 7);
        wait_cycles(5);
        check("t3_count", q_sad.size(), 3);
        pop_check("t3_c5", 100, 5);
        pop_check("t3_c6", 50, 6);
        pop_check("t3_c7", 50, 7);
        check("t3_best_sad", int'(bus.best_sad), 50);
        check("t3_best_idx", int'(bus.best_idx), 6);
        check("t3_best_pulses", best_pulses - p0, 1);

        // Backpressure: sad_rdy low for 3 cycles while 4x4 rows keep streaming.
        q_sad.delete(); q_idx.delete();
        p0 = best_pulses;
        bus.sad_rdy = 1'b0;
        fork
            begin
                for (int r = 0; r < 4; r++) send_row(one(20, 0, 20), '0, 0, 10, 1'b0);
                for (int r = 0; r < 4; r++) send_row('0, one(9, 0, 9), 0, 11, 1'b0);
                for (int r = 0; r < 4; r++) send_row(one(100, 0, 100), one(99, 0, 99), 0, 12, r == 3);
            end
            begin
                int waited;
                waited = 0;
                do begin
                    @(posedge clk);
                    #1;
                    waited++;
                end while (!bus.sad_vld && waited < 30);
                for (int i = 0; i < 3; i++) begin
                    check("t4_stall_vld", int'(bus.sad_vld), 1);
                    check("t4_stall_row_rdy", int'(bus.row_rdy), 0);
                    check("t4_stall_sad", int'(bus.sad), 320);
                    @(posedge clk);
                    #1;
                end
                bus.sad_rdy = 1'b1;
            end
        join
        wait_cycles(6);
        check("t4_count", q_sad.size(), 3);
        pop_check("t4_c10", 320, 10);
        pop_check("t4_c11", 144, 11);
        pop_check("t4_c12", 16, 12);
        check("t4_best_sad", int'(bus.best_sad), 16);
        check("t4_best_idx", int'(bus.best_idx), 12);
        check("t4_best_pulses", best_pulses - p0, 1);

        // Mode, index and last flag changed mid-block are ignored: 16 * (1+..+16).
        q_sad.delete(); q_idx.delete();
        p0 = best_pulses;
        for (int r = 0; r < 16; r++)
            send_row(one(r + 1, 0, r + 1), '0, (r < 3) ? 2 : 0, (r == 0) ? 20 : 99, r == 5);
        wait_cycles(5);
        check("t5_count", q_sad.size(), 1);
        pop_check("t5", 2176, 20);
        check("t5_best_pulses", best_pulses - p0, 0);

        // Reset after row 7 of 16 discards the candidate and restarts the search.
        for (int r = 0; r < 8; r++) send_row(one(1, 0, 1), '0, 2, 25, 1'b0);
        rstn = 1'b0;
        q_sad.delete(); q_idx.delete();
        #1;
        check("t6_rst_row_rdy",  int'(bus.row_rdy),  0);
        check("t6_rst_sad",      int'(bus.sad),      0);
        check("t6_rst_sad_idx",  int'(bus.sad_idx),  0);
        check("t6_rst_sad_vld",  int'(bus.sad_vld),  0);
        check("t6_rst_best_sad", int'(bus.best_sad), 0);
        check("t6_rst_best_idx", int'(bus.best_idx), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        wait_cycles(2);
        p0 = best_pulses;
        for (int r = 0; r < 16; r++) send_row(one(255, 0, 255), one(245, 0, 245), 2, 30, r == 15);
        wait_cycles(6);
        check("t6_count", q_sad.size(), 1);
        pop_check("t6", 2560, 30);
        check("t6_best_sad", int'(bus.best_sad), 2560);
        check("t6_best_idx", int'(bus.best_idx), 30);
        check("t6_best_pulses", best_pulses - p0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
